serial_subtractor4: RTL and testbench

//  Bit-serial two's-complement subtractor, the inverse operation of the 4-bit ripple adder: diff = a - b.

---
 rtl/serial_subtractor4_pkg.sv | 13 +
 rtl/serial_subtractor4_if.sv | 39 +++
 rtl/serial_subtractor4_full_adder_cell.sv | 13 +
 rtl/serial_subtractor4.sv | 130 +++++++++++++
 tb/tb_serial_subtractor4.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor4_pkg.sv
// Shared ALU definitions for the bit-serial subtractor: FSM state
// encoding and the default operand width.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor4_if.sv
// Operand/result handshake bundle for serial_subtractor4.
// The mode signal exists only when SERIAL_SUB_ADD_EN is defined.
interface serial_subtractor4_if
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_SUB_ADD_EN
    logic             mode;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             carryout;
    logic             overflow;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_ADD_EN
        output mode,
`endif
        input  in_ready, out_valid, diff, carryout, overflow
    );

    // The serial subtractor itself.
    modport slave (
        input  in_valid, a, b, out_ready,
`ifdef SERIAL_SUB_ADD_EN
        input  mode,
`endif
        output in_ready, out_valid, diff, carryout, overflow
    );

endinterface

// File: rtl/serial_subtractor4_full_adder_cell.sv
// Single 1-bit full adder; the only arithmetic element of the serial datapath.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one
// bit per clock through a single full-adder cell with b inverted and
// carry-in 1. carryout=1 means no unsigned borrow; overflow is signed.
// Optional feature: define SERIAL_SUB_ADD_EN to add a mode input
// (0 = subtract, 1 = add) sampled with the operands.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// SHIFT | processing one bit per edge
// DONE  | result held until out_ready
module serial_subtractor4
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor4_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_nb;
    logic [WIDTH-1:0]   r_diff;
    logic [CNT_W-1:0]   r_count;
    logic               r_carry;
    logic               r_cin_msb;
    logic               r_carryout;
    logic               r_overflow;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_sum;
    logic               w_cout;
    logic               w_last;
    logic               w_b_load_inv;

    assign w_last = (r_count == CNT_W'(WIDTH - 1));

`ifdef SERIAL_SUB_ADD_EN
    assign w_b_load_inv = ~bus.mode;
`else
    assign w_b_load_inv = 1'b1;
`endif

    full_adder_cell u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_nb[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_next = SHIFT;
            SHIFT:   if (w_last)        w_state_next = DONE;
            DONE:    if (bus.out_ready) w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // Handshake outputs registered from the next state so they track the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
        end
    end

    // Operand load, serial shift and flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_nb       <= '0;
            r_diff     <= '0;
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_cin_msb  <= 1'b0;
            r_carryout <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_nb    <= w_b_load_inv ? ~bus.b : bus.b;
                        r_carry <= w_b_load_inv;
                        r_count <= '0;
                    end
                end
                SHIFT: begin
                    r_diff  <= {w_sum, r_diff[WIDTH-1:1]};
                    r_a     <= r_a >> 1;
                    r_nb    <= r_nb >> 1;
                    r_carry <= w_cout;
                    r_count <= r_count + 1'b1;
                    // Carry out of bit WIDTH-2 is the carry into the MSB.
                    if (r_count == CNT_W'(WIDTH - 2))
                        r_cin_msb <= w_cout;
                    if (w_last) begin
                        r_carryout <= w_cout;
                        r_overflow <= r_cin_msb ^ w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.carryout  = r_carryout;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_serial_subtractor4.sv
// Scoreboard bench for serial_subtractor4 (WIDTH=4).
module tb_serial_subtractor4;

    typedef struct packed {
        logic [3:0] diff;
        logic       co;
        logic       ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    serial_subtractor4_if #(.WIDTH(4)) bus ();

    serial_subtractor4 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b, input logic m);
        exp_t       r;
        logic [4:0] s;
        if (m) s = {1'b0, a} + {1'b0, b};
        else   s = {1'b0, a} + {1'b0, ~b} + 5'd1;
        r.diff = s[3:0];
        r.co   = s[4];
        if (m) r.ovf = (a[3] == b[3]) && (s[3] != a[3]);
        else   r.ovf = (a[3] != b[3]) && (s[3] != a[3]);
        return r;
    endfunction

    task automatic drive(input logic [3:0] a_i, input logic [3:0] b_i, input logic m_i);
        bus.a = a_i;
        bus.b = b_i;
`ifdef SERIAL_SUB_ADD_EN
        bus.mode = m_i;
`endif
        bus.in_valid = 1'b1;
    endtask

    task automatic do_op(input logic [3:0] a_i, input logic [3:0] b_i,
                         input logic m_i, input int stall);
        int         n;
        exp_t       e;
        logic [3:0] held;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
        check("in_ready_before_op", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        drive(a_i, b_i, m_i);
        sb.push_back(model(a_i, b_i, m_i));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
        n = 0;
        while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("latency", n, 32'd4);
        held = bus.diff;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            drive(~a_i, a_i, 1'b0);
            @(posedge clk); #1;
            check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_diff", {28'd0, bus.diff}, {28'd0, held});
        end
        bus.in_valid = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("diff", {28'd0, bus.diff}, {28'd0, e.diff});
            check("carryout", {31'd0, bus.carryout}, {31'd0, e.co});
            check("overflow", {31'd0, bus.overflow}, {31'd0, e.ovf});
        end else begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef SERIAL_SUB_ADD_EN
        bus.mode = 1'b0;
`endif
        #12;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_diff", {28'd0, bus.diff}, 32'd0);
        check("rst_flags", {30'd0, bus.carryout, bus.overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // out_ready while idle must not disturb anything
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_out_ready_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("idle_out_ready_valid", {31'd0, bus.out_valid}, 32'd0);
        @(negedge clk);
        bus.out_ready = 1'b0;

        do_op(4'b0111, 4'b0011, 1'b0, 0);
        do_op(4'b0011, 4'b0100, 1'b0, 0);
        do_op(4'b0000, 4'b0000, 1'b0, 0);
        do_op(4'b1000, 4'b0001, 1'b0, 1);
        do_op(4'b0111, 4'b1111, 1'b0, 3);

        // reset after two bits of SHIFT
        @(negedge clk);
        drive(4'b0101, 4'b0010, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_diff", {28'd0, bus.diff}, 32'd0);
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(4'b0101, 4'b0010, 1'b0, 0);

`ifdef SERIAL_SUB_ADD_EN
        do_op(4'b0100, 4'b0100, 1'b1, 0);
        do_op(4'b1100, 4'b1100, 1'b1, 1);
`endif

        for (int k = 0; k < 6; k++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
`ifdef SERIAL_SUB_ADD_EN
            do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
`else
            do_op(ra, rb, 1'b0, int'($urandom_range(0, 2)));
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
